// File: rtl/rcas_multicycle.sv
// rcas_multicycle: chunked ripple-carry add/sub with valid/ready, CHUNK bits per clock; RCAS_OVERFLOW_DETECT_EN adds signed overflow output ovf
module rcas_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out
`ifdef RCAS_OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic c_out_q, c_out_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic cy, last;
`ifdef RCAS_OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign c_out = c_out_q;
  // one slice of the ripple chain per cycle, plus the IDLE/CALC/DONE handshake sequencing
  always_comb begin
    a_sl = a_q[idx_q*CHUNK +: CHUNK];
    b_sl = b_q[idx_q*CHUNK +: CHUNK];
    {cy, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    last = idx_q == IW'(NUM_CHUNKS - 1);
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    result_d = result_q;
    c_out_d = c_out_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef RCAS_OVERFLOW_DETECT_EN
    ovf_d = ovf_q;
`endif
    if (state_q == IDLE && in_valid) begin
      state_d = CALC;
      a_d = a;
      b_d = sel ? ~b : b;
      carry_d = sel;
      idx_d = '0;
      in_ready_d = 1'b0;
    end else if (state_q == CALC) begin
      acc_d[idx_q*CHUNK +: CHUNK] = s_sl;
      carry_d = cy;
      idx_d = idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        result_d = acc_d;
        c_out_d = cy;
        out_valid_d = 1'b1;
`ifdef RCAS_OVERFLOW_DETECT_EN
        ovf_d = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1] ^ cy;
`endif
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      in_ready_d = 1'b1;
    end
  end
  // state registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      c_out_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef RCAS_OVERFLOW_DETECT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      result_q <= result_d;
      c_out_q <= c_out_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef RCAS_OVERFLOW_DETECT_EN
      ovf_q <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_rcas_multicycle.sv
// tb_rcas_multicycle: scoreboard bench for rcas_multicycle at 16/4, 8/8 and 32/8
module tb_rcas_multicycle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a_i [3];
  logic [31:0] b_i [3];
  logic [31:0] r_o [3];
  logic sel_i [3], iv_i [3], or_i [3], ir_o [3], ov_o [3], c_o [3];
`ifdef RCAS_OVERFLOW_DETECT_EN
  logic f_o [3];
`endif
  logic [15:0] r0;
  logic [7:0] r1;
  logic [31:0] r2;
  assign r_o[0] = {16'h0, r0};
  assign r_o[1] = {24'h0, r1};
  assign r_o[2] = r2;
  int wid [3] = '{16, 8, 32};
  int nch [3] = '{4, 1, 4};
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rcas_multicycle #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .rst(rst), .in_valid(iv_i[0]), .in_ready(ir_o[0]),
    .a(a_i[0][15:0]), .b(b_i[0][15:0]), .sel(sel_i[0]), .out_valid(ov_o[0]), .out_ready(or_i[0]),
    .result(r0), .c_out(c_o[0])
`ifdef RCAS_OVERFLOW_DETECT_EN
    , .ovf(f_o[0])
`endif
  );
  rcas_multicycle #(.WIDTH(8), .CHUNK(8)) u1 (.clk(clk), .rst(rst), .in_valid(iv_i[1]), .in_ready(ir_o[1]),
    .a(a_i[1][7:0]), .b(b_i[1][7:0]), .sel(sel_i[1]), .out_valid(ov_o[1]), .out_ready(or_i[1]),
    .result(r1), .c_out(c_o[1])
`ifdef RCAS_OVERFLOW_DETECT_EN
    , .ovf(f_o[1])
`endif
  );
  rcas_multicycle #(.WIDTH(32), .CHUNK(8)) u2 (.clk(clk), .rst(rst), .in_valid(iv_i[2]), .in_ready(ir_o[2]),
    .a(a_i[2]), .b(b_i[2]), .sel(sel_i[2]), .out_valid(ov_o[2]), .out_ready(or_i[2]),
    .result(r2), .c_out(c_o[2])
`ifdef RCAS_OVERFLOW_DETECT_EN
    , .ovf(f_o[2])
`endif
  );

  typedef struct {logic [31:0] r; logic c; logic o; int acc;} exp_t;
  typedef struct {logic s; logic [15:0] a; logic [15:0] b; logic [15:0] r; logic c; logic o;} vec_t;
  exp_t sb [$];
  vec_t vt [8];
  int total = 0;
  int bad = 0;
  int act = 0;
  int rdy_mode = 0;
  logic prev_ov = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic exp_t model(int k, logic s, logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [32:0] full;
    logic [31:0] m;
    logic am, bm, rm;
    m = wid[k] == 32 ? 32'hFFFF_FFFF : (32'd1 << wid[k]) - 32'd1;
    full = {1'b0, a} + {1'b0, b};
    e.r = (s ? a - b : a + b) & m;
    e.c = s ? (a >= b) : full[wid[k]];
    am = a[wid[k]-1];
    bm = b[wid[k]-1];
    rm = e.r[wid[k]-1];
    e.o = s ? (am != bm && rm != am) : (am == bm && rm != am);
    e.acc = 0;
    return e;
  endfunction

  task automatic do_op(int k, logic s, logic [31:0] av, logic [31:0] bv, exp_t e);
    int n = 0;
    a_i[k] = av;
    b_i[k] = bv;
    sel_i[k] = s;
    iv_i[k] = 1'b1;
    while (!ir_o[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir_o[k]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout k=%0d in_ready=%b want 1", k, ir_o[k]);
    end else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    iv_i[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !ir_o[act]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    or_i[act] = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    if (ov_o[act] && !prev_ov) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out_valid k=%0d out_valid=1 want 0", act);
      end else chk("latency", cyc - sb[0].acc, nch[act]);
    end
    if (ov_o[act] && or_i[act] && sb.size() != 0) begin
      e = sb.pop_front();
      chk("result", r_o[act], e.r);
      chk("c_out", {31'b0, c_o[act]}, {31'b0, e.c});
`ifdef RCAS_OVERFLOW_DETECT_EN
      chk("ovf", {31'b0, f_o[act]}, {31'b0, e.o});
`endif
    end
    prev_ov = ov_o[act];
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] av, bv, m;
    logic s;
    for (int k = 0; k < 3; k++) begin
      a_i[k] = '0;
      b_i[k] = '0;
      sel_i[k] = 1'b0;
      iv_i[k] = 1'b0;
      or_i[k] = 1'b0;
    end
    vt[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vt[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vt[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vt[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vt[7] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", {31'b0, ir_o[k]}, 1);
      chk("rst_out_valid", {31'b0, ov_o[k]}, 0);
      chk("rst_result", r_o[k], 0);
      chk("rst_c_out", {31'b0, c_o[k]}, 0);
    end
    for (int i = 0; i < 8; i++) begin
      e.r = {16'h0, vt[i].r};
      e.c = vt[i].c;
      e.o = vt[i].o;
      do_op(0, vt[i].s, {16'h0, vt[i].a}, {16'h0, vt[i].b}, e);
    end
    drain();
    @(posedge clk);
    rdy_mode = 2;
    @(negedge clk);
    e.r = 32'h1010;
    e.c = 1'b0;
    e.o = 1'b0;
    do_op(0, 1'b0, 32'h0F0F, 32'h0101, e);
    for (int n = 0; n < 50 && !ov_o[0]; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      a_i[0] = $urandom;
      b_i[0] = $urandom;
      iv_i[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_result", r_o[0], 32'h1010);
      chk("bp_in_ready", {31'b0, ir_o[0]}, 0);
      chk("bp_out_valid", {31'b0, ov_o[0]}, 1);
    end
    @(posedge clk);
    rdy_mode = 0;
    @(negedge clk);
    a_i[0] = 32'h3;
    b_i[0] = 32'h2;
    sel_i[0] = 1'b1;
    iv_i[0] = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'b0, ir_o[0]}, 1);
    chk("release_out_valid", {31'b0, ov_o[0]}, 0);
    e = model(0, 1'b1, 32'h3, 32'h2);
    do_op(0, 1'b1, 32'h3, 32'h2, e);
    drain();
    e = model(0, 1'b0, 32'h1111, 32'h2222);
    do_op(0, 1'b0, 32'h1111, 32'h2222, e);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_result", r_o[0], 0);
    chk("abort_in_ready", {31'b0, ir_o[0]}, 1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_out_valid", {31'b0, ov_o[0]}, 0);
      @(negedge clk);
    end
    e = model(0, 1'b0, 32'hABCD, 32'h1111);
    do_op(0, 1'b0, 32'hABCD, 32'h1111, e);
    drain();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      act = k;
      rdy_mode = 1;
      @(negedge clk);
      m = wid[k] == 32 ? 32'hFFFF_FFFF : (32'd1 << wid[k]) - 32'd1;
      for (int i = 0; i < 30; i++) begin
        av = $urandom & m;
        bv = $urandom & m;
        s = 1'($urandom_range(0, 1));
        if (i == 0) begin av = m; bv = 32'd1; s = 1'b0; end
        if (i == 1) begin av = 32'd0; bv = 32'd1; s = 1'b1; end
        e = model(k, s, av, bv);
        do_op(k, s, av, bv, e);
      end
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
